// File: rtl/alu_exec_stage.sv
// RV32I execute stage: single-cycle logic/arith/compare ops and iterative shifts
// (SHIFT_STEP bits per cycle), valid/ready handshakes on both sides.
module alu_exec_stage #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal_op,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

   localparam logic [5:0] STEP = 6'(SHIFT_STEP);

   state_t                  state_q, state_d;
   shkind_t                 kind_q, kind_d;
   logic [XLEN-1:0]         result_q, result_d;
   logic                    illegal_q, illegal_d;
   logic signed [XLEN-1:0]  work_q, work_d;
   logic [4:0]              cnt_q, cnt_d;

   logic                    accept;
   logic                    op_legal, op_shift;
   logic [4:0]              shamt;
   shkind_t                 op_kind;
   logic [5:0]              step_k;
   logic signed [XLEN-1:0]  shifted;

   function automatic logic [XLEN-1:0] alu_compute(input logic [4:0] op,
                                                   input logic signed [XLEN-1:0] a,
                                                   input logic signed [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      r = '0;
      case (op)
         5'd1, 5'd2:   r = a + b;
         5'd3, 5'd4:   r = a | b;
         5'd5, 5'd6:   r = a ^ b;
         5'd7, 5'd8:   r = a & b;
         5'd9:         r = a - b;
         5'd10, 5'd11: r = {{(XLEN-1){1'b0}}, (a < b)};
         5'd12, 5'd13: r = {{(XLEN-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
         default:      r = '0;
      endcase
      return r;
   endfunction

   assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign out_valid  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign result     = result_q;
   assign illegal_op = illegal_q;

   // Flush wins over both a new accept and the DONE handshake.
   assign accept   = in_valid & in_ready & ~flush;
   assign op_legal = (alu_op >= 5'd1) && (alu_op <= 5'd19);
   assign op_shift = (alu_op >= 5'd14) && (alu_op <= 5'd19);
   assign shamt    = op_b[4:0];

   always_comb begin
      op_kind = SH_LL;
      case (alu_op)
         5'd15, 5'd18: op_kind = SH_RL;
         5'd16, 5'd19: op_kind = SH_RA;
         default:      op_kind = SH_LL;
      endcase
   end

   // Arithmetic right shift of the working value keeps replicating the original op_a[31].
   always_comb begin
      step_k  = ({1'b0, cnt_q} < STEP) ? {1'b0, cnt_q} : STEP;
      shifted = work_q;
      case (kind_q)
         SH_RL:   shifted = work_q >> step_k;
         SH_RA:   shifted = work_q >>> step_k;
         default: shifted = work_q << step_k;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      result_d  = result_q;
      illegal_d = illegal_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            SHIFT: begin
               work_d = shifted;
               cnt_d  = cnt_q - step_k[4:0];
               if (cnt_q == step_k[4:0]) begin
                  result_d = shifted;
                  state_d  = DONE;
               end
            end
            default: begin
               if (accept) begin
                  illegal_d = ~op_legal;
                  state_d   = DONE;
                  if (!op_legal) begin
                     result_d = '0;
                  end else if (op_shift && (shamt != 5'd0)) begin
                     work_d  = op_a;
                     cnt_d   = shamt;
                     kind_d  = op_kind;
                     state_d = SHIFT;
                  end else if (op_shift) begin
                     result_d = op_a;
                  end else begin
                     result_d = alu_compute(alu_op, op_a, op_b);
                  end
               end else if ((state_q == DONE) && out_ready) begin
                  state_d = IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         kind_q    <= SH_LL;
         result_q  <= '0;
         illegal_q <= 1'b0;
         work_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_exec_stage;

   localparam int STEP = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  alu_op = 5'd0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        illegal_op;
   logic        busy;

   logic        v8 = 1'b0, r8 = 1'b1, f8 = 1'b0;
   logic        ir8, ov8, ill8, busy8;
   logic [31:0] res8;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_exec_stage #(.XLEN(32), .SHIFT_STEP(STEP)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .illegal_op(illegal_op), .busy(busy));

   alu_exec_stage #(.XLEN(32), .SHIFT_STEP(8)) dut8 (
      .clk(clk), .rst(rst), .flush(f8), .in_valid(v8), .in_ready(ir8),
      .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .out_valid(ov8),
      .out_ready(r8), .result(res8), .illegal_op(ill8), .busy(busy8));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         1, 2:   return a + b;
         3, 4:   return a | b;
         5, 6:   return a ^ b;
         7, 8:   return a & b;
         9:      return a - b;
         10, 11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         12, 13: return (a < b) ? 32'd1 : 32'd0;
         14, 17: return a << sh;
         15, 18: return a >> sh;
         16, 19: return $unsigned($signed(a) >>> sh);
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_extra_cycles(input logic [4:0] op, input logic [31:0] b);
      if (op >= 14 && op <= 19) return (int'(b[4:0]) + STEP - 1) / STEP;
      return 0;
   endfunction

   // Reference model: one op in flight, with the number of cycles still to wait.
   bit          m_have = 0;
   int          m_wait = 0;
   logic [31:0] m_res = '0, m_resreg = '0;
   logic        m_ill = 0;

   initial begin
      bit exp_ov, exp_ir;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_result", result, 32'd0);
            chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            m_have = 0; m_wait = 0; m_resreg = '0;
         end else begin
            exp_ov = m_have && (m_wait == 0);
            exp_ir = !m_have || (exp_ov && out_ready);
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            chk("busy", {31'd0, busy}, {31'd0, m_have});
            chk("result", result, m_resreg);
            if (exp_ov) chk("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
            if (flush) begin
               m_have = 0;
            end else if (in_valid && exp_ir) begin
               m_have = 1;
               m_ill  = !(alu_op >= 1 && alu_op <= 19);
               m_res  = ref_result(alu_op, op_a, op_b);
               m_wait = ref_extra_cycles(alu_op, op_b);
               if (m_wait == 0) m_resreg = m_res;
            end else if (exp_ov && out_ready) begin
               m_have = 0;
            end else if (m_have && m_wait > 0) begin
               m_wait--;
               if (m_wait == 0) m_resreg = m_res;
            end
         end
      end
   end

   task automatic cyc(input logic v, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic r, input logic f);
      @(posedge clk); #1;
      in_valid = v; alu_op = op; op_a = a; op_b = b; out_ready = r; flush = f;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      @(posedge clk); #1;
      in_valid = 0; out_ready = 1; flush = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL idle_timeout: busy still %0d after 100 cycles", busy);
      end
   endtask

   task automatic dir_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic exp_ill);
      cyc(1, op, a, b, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_result"}, result, exp);
      chk({name, "_illegal"}, {31'd0, illegal_op}, {31'd0, exp_ill});
   endtask

   initial begin
      int lat, shc;
      logic [31:0] prev;
      logic [31:0] sums [4];
      logic [4:0]  rop;
      logic [31:0] ra, rb;

      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Test 1 and 4: single-cycle ops with literal results
      dir_op("add_wrap", 5'd1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0);
      dir_op("slt", 5'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 0);
      dir_op("sltu", 5'd12, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 0);
      dir_op("slli0", 5'd14, 32'h0000_1234, 32'hFFFF_FFE0, 32'h0000_1234, 0);
      dir_op("illegal0", 5'd0, 32'h1111_1111, 32'h2222_2222, 32'd0, 1);
      dir_op("illegal25", 5'd25, 32'h1111_1111, 32'h2222_2222, 32'd0, 1);
      dir_op("clear_ill", 5'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 0);

      // Test 2: SUB held under back-pressure
      cyc(1, 5'd9, 32'h0, 32'h1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         chk("sub_hold_result", result, 32'hFFFF_FFFF);
         chk("sub_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("sub_hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      wait_idle();

      // Test 3: SRA by 31 at STEP=1
      cyc(1, 5'd19, 32'h8000_0000, 32'h0000_001F, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      lat = 1; shc = 0;
      while (lat < 60) begin
         @(negedge clk);
         if (out_valid) break;
         if (busy) shc++;
         @(posedge clk);
         lat++;
      end
      chk("sra_latency", 32'(lat), 32'd32);
      chk("sra_shift_cycles", 32'(shc), 32'd31);
      chk("sra_result", result, 32'hFFFF_FFFF);
      wait_idle();

      // Test 3b: same SRA at STEP=8
      @(posedge clk); #1;
      alu_op = 5'd19; op_a = 32'h8000_0000; op_b = 32'h0000_001F; v8 = 1;
      @(posedge clk); #1;
      v8 = 0;
      lat = 1;
      while (lat < 60) begin
         @(negedge clk);
         if (ov8) break;
         @(posedge clk);
         lat++;
      end
      chk("sra8_latency", 32'(lat), 32'd5);
      chk("sra8_result", res8, 32'hFFFF_FFFF);

      // Test 5: four back-to-back ADDs
      for (int i = 0; i < 4; i++) begin
         sums[i] = 32'h1000_0000 * (i + 1) + 32'(i);
         cyc(1, 5'd1, 32'h1000_0000 * (i + 1), 32'(i), 1, 0);
         if (i > 0) begin
            @(negedge clk);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_result", result, sums[i-1]);
         end
      end
      cyc(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("stream_last", result, 32'h4000_0003);
      wait_idle();

      // Test 6: flush on the 5th SHIFT cycle of SLL 1 by 20
      prev = result;
      cyc(1, 5'd17, 32'h1, 32'd20, 1, 0);
      repeat (4) cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_result", result, prev);
      repeat (25) cyc(0, 0, 0, 0, 1, 0);

      // Test 6b: reset pulse mid-SHIFT
      cyc(1, 5'd17, 32'h1, 32'd20, 1, 0);
      repeat (3) cyc(0, 0, 0, 0, 1, 0);
      @(posedge clk); #1 rst = 1;
      #1;
      chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_result", result, 32'd0);
      @(posedge clk); #1 rst = 0;
      wait_idle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rop = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(1, 19));
         ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
         cyc(($urandom_range(0, 9) < 7), rop, ra, rb, ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 59) == 0));
      end
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
